// File: rtl/ultrasonic_ranger_pkg.sv
// rtl/ultrasonic_ranger_pkg.sv - shared state encoding, default timing and width helpers for the ranger
//
// Purpose : default timing constants derived from a 50 MHz clock, the FSM
//           state encoding, and a helper that sizes the cycle counters.
// Ports   : none (package).
package ultrasonic_ranger_pkg;

    localparam int CLK_HZ = 50_000_000;

    // 10 us trigger, 58.3 us of echo per cm, 25 ms echo window, 60 ms period.
    localparam int DEF_TRIG_CYCLES    = CLK_HZ / 100_000;
    localparam int DEF_CYCLES_PER_CM  = (CLK_HZ / 1_000_000) * 583 / 10;
    localparam int DEF_TIMEOUT_CYCLES = CLK_HZ / 40;
    localparam int DEF_PERIOD_CYCLES  = (CLK_HZ / 1000) * 60;
    localparam int DEF_DIST_W         = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_TRIG      = 3'd1;
    localparam state_t ST_WAIT_RISE = 3'd2;
    localparam state_t ST_MEASURE   = 3'd3;
    localparam state_t ST_HOLDOFF   = 3'd4;

    // Both the period and timeout counters only ever need to hold values
    // below the larger of the two limits.
    function automatic int cnt_width(input int period_cycles, input int timeout_cycles);
        int largest;
        largest = (period_cycles > timeout_cycles) ? period_cycles : timeout_cycles;
        return (largest < 2) ? 1 : $clog2(largest);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_PERIOD_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// rtl/ultrasonic_ranger_if.sv - sensor pins and measurement result bundle
//
// Purpose : groups the sensor pins and the measurement result signals.
// Signals : enable      - run continuous measurements while high
//           echo        - raw sensor echo, asynchronous to clk
//           trigger     - sensor trigger pin
//           distance_cm - last valid distance in cm
//           valid       - one-cycle pulse when distance_cm updates
//           timeout     - one-cycle pulse when a measurement is abandoned
//           busy        - ranger is not idle
// Modports: master - the ranger itself; slave - the controlling logic.
interface ultrasonic_ranger_if
    import ultrasonic_ranger_pkg::*;
#(
    parameter int DIST_W = DEF_DIST_W
);
    logic              enable;
    logic              echo;
    logic              trigger;
    logic [DIST_W-1:0] distance_cm;
    logic              valid;
    logic              timeout;
    logic              busy;

    modport master (
        input  enable,
        input  echo,
        output trigger,
        output distance_cm,
        output valid,
        output timeout,
        output busy
    );

    modport slave (
        output enable,
        output echo,
        input  trigger,
        input  distance_cm,
        input  valid,
        input  timeout,
        input  busy
    );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser
//
// Purpose : brings an asynchronous level into the clk domain.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset, clears both stages
//           d     - asynchronous input
//           q     - synchronised output, two clk cycles behind d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04-style trigger/echo ranger with cm conversion
//
// Purpose : fires a fixed trigger pulse, times the returned echo and converts
//           it to whole centimetres by counting clk cycles per cm, repeating
//           every PERIOD_CYCLES while enabled.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           sensor - ultrasonic_ranger_if.master (enable, echo in;
//                    trigger, distance_cm, valid, timeout, busy out)
module ultrasonic_ranger
    import ultrasonic_ranger_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int DIST_W         = DEF_DIST_W
) (
    input  logic                clk,
    input  logic                rst_n,
    ultrasonic_ranger_if.master sensor
);
    localparam int CNT_W = cnt_width(PERIOD_CYCLES, TIMEOUT_CYCLES);
    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX     = {DIST_W{1'b1}};

    state_t            state;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] dist_q;
    logic              trig_q;
    logic              valid_q;
    logic              tmo_q;

    logic echo_s;
    logic echo_s_d;
    logic rise;
    logic fall;
    logic active;
    logic tmo_hit;

    sync_2ff #(
        .WIDTH (1)
    ) u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sensor.echo),
        .q     (echo_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s_d <= 1'b0;
        end else begin
            echo_s_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_s_d;
    assign fall = ~echo_s & echo_s_d;

    // States in which dropping enable abandons the measurement outright.
    assign active  = (state == ST_TRIG) || (state == ST_WAIT_RISE) || (state == ST_MEASURE);
    // Last cycle of the echo window; the pulse itself appears one cycle later,
    // exactly TIMEOUT_CYCLES after WAIT_RISE entry.
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            tmo_cnt    <= '0;
            sub_cnt    <= '0;
            cm_cnt     <= '0;
            dist_q     <= '0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
            period_cnt <= period_cnt + 1'b1;

            if (active && !sensor.enable) begin
                // Abort silently: no valid, no timeout, distance untouched.
                state      <= ST_IDLE;
                trig_q     <= 1'b0;
                period_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        period_cnt <= '0;
                        if (sensor.enable) begin
                            state  <= ST_TRIG;
                            trig_q <= 1'b1;
                        end
                    end

                    ST_TRIG: begin
                        // The period counter doubles as the trigger width timer,
                        // since it restarts at 0 on every TRIG entry.
                        if (period_cnt == TRIG_LAST) begin
                            state   <= ST_WAIT_RISE;
                            trig_q  <= 1'b0;
                            tmo_cnt <= '0;
                        end
                    end

                    ST_WAIT_RISE: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_hit) begin
                            tmo_q <= 1'b1;
                            state <= ST_HOLDOFF;
                        end else if (rise) begin
                            // The rise cycle is the first high cycle of the echo.
                            state   <= ST_MEASURE;
                            sub_cnt <= SUB_W'(1);
                            cm_cnt  <= '0;
                        end
                    end

                    ST_MEASURE: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (fall) begin
                            dist_q  <= cm_cnt;
                            valid_q <= 1'b1;
                            state   <= ST_HOLDOFF;
                        end else if (tmo_hit) begin
                            tmo_q <= 1'b1;
                            state <= ST_HOLDOFF;
                        end else if (echo_s) begin
                            // Divider-free cm conversion: one cm per CYCLES_PER_CM
                            // high cycles, saturating rather than wrapping.
                            if (sub_cnt == SUB_LAST) begin
                                sub_cnt <= '0;
                                if (cm_cnt != CM_MAX) begin
                                    cm_cnt <= cm_cnt + 1'b1;
                                end
                            end else begin
                                sub_cnt <= sub_cnt + 1'b1;
                            end
                        end
                    end

                    ST_HOLDOFF: begin
                        // >= keeps the FSM from stalling should the echo window
                        // ever be configured longer than the period.
                        if (period_cnt >= PERIOD_LAST) begin
                            period_cnt <= '0;
                            if (sensor.enable) begin
                                state  <= ST_TRIG;
                                trig_q <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end

                    default: begin
                        state      <= ST_IDLE;
                        trig_q     <= 1'b0;
                        period_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign sensor.trigger     = trig_q;
    assign sensor.distance_cm = dist_q;
    assign sensor.valid       = valid_q;
    assign sensor.timeout     = tmo_q;
    assign sensor.busy        = (state != ST_IDLE);

endmodule
